// File: rtl/skylark_bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skylark_bnn_pkg
// Description : Shared defaults, types and helpers for the Skylark-V BNN
//               dot-product path.
// Revision    : 1.0 - initial release
// ============================================================================
package skylark_bnn_pkg;

    // Default operand width and largest supported matrix_size in bits
    localparam int c_XLEN_DEFAULT   = 32;
    localparam int c_MAX_MS_DEFAULT = 1024;

    // ExPath select value that routes an instruction to the BNN unit
    localparam logic [2:0] c_EXPATH_BNN = 3'd5;

    // Configuration register selector
    typedef enum logic [0:0] {
        CFG_MS = 1'b0,
        CFG_AT = 1'b1
    } cfg_sel_t;

    // Width needed to hold any count from 0 up to maxMs inclusive
    function automatic int accWidth(input int maxMs);
        return $clog2(maxMs + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_popcount.sv
`default_nettype none
// ============================================================================
// Module      : bnn_popcount
// Description : Combinational popcount of (i_data & i_mask), built as a
//               balanced pairwise adder tree over a power-of-two leaf set.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_popcount #(
    parameter int W = 32
) (
    input  logic [W-1:0]             i_data,
    input  logic [W-1:0]             i_mask,
    output logic [$clog2(W+1)-1:0]   o_count
);

    localparam int c_OUT_W  = $clog2(W + 1);
    localparam int c_LEVELS = $clog2(W);
    localparam int c_LEAVES = 1 << c_LEVELS;

    // Masked bits zero-padded up to the leaf count so the tree stays balanced
    logic [c_LEAVES-1:0] w_bits;
    logic [c_OUT_W-1:0]  w_tree [c_LEAVES];

    assign w_bits = c_LEAVES'(i_data & i_mask);

    // Reduce the leaves in place: each level halves the number of live nodes
    always_comb begin
        for (int i = 0; i < c_LEAVES; i++) begin
            w_tree[i] = c_OUT_W'(w_bits[i]);
        end
        for (int lvl = 1; lvl <= c_LEVELS; lvl++) begin
            for (int i = 0; i < c_LEAVES; i++) begin
                if (i < (c_LEAVES >> lvl)) begin
                    w_tree[i] = w_tree[2*i] + w_tree[2*i+1];
                end
            end
        end
    end

    assign o_count = w_tree[0];

endmodule
`default_nettype wire

// File: rtl/bnn_dot_unit.sv
`default_nettype none
// ============================================================================
// Module      : bnn_dot_unit
// Description : Multi-cycle BNN dot product. Streams one XLEN-bit operand
//               pair per cycle, accumulates masked XNOR-popcounts over
//               ceil(ms/XLEN) words and emits a count or a thresholded bit.
//               Two pipeline stages: popcount, then accumulate/compare.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_dot_unit
    import skylark_bnn_pkg::*;
#(
    parameter int XLEN   = c_XLEN_DEFAULT,
    parameter int MAX_MS = c_MAX_MS_DEFAULT,
    parameter int ACC_W  = accWidth(MAX_MS),
    parameter int CNT_W  = $clog2((MAX_MS + XLEN - 1) / XLEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ms_we,
    input  logic             at_we,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic             valid_in,
    input  logic             en_threshold,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic             busy,
    output logic [ACC_W-1:0] ms_out
);

    localparam int c_PC_W = $clog2(XLEN + 1);

    // Configuration registers
    logic [ACC_W-1:0]  r_ms;
    logic [ACC_W-1:0]  r_at;

    // Chunk counter and stage-1 registers
    logic [CNT_W-1:0]  r_chunkCnt;
    logic              r_v1;
    logic [c_PC_W-1:0] r_pc1;
    logic              r_last1;
    logic              r_thr1;

    // Stage-2 registers
    logic [ACC_W-1:0]  r_acc;
    logic              r_resultValid;
    logic [XLEN-1:0]   r_result;

    // Combinational helpers
    logic [ACC_W:0]    w_msRound;
    logic [ACC_W:0]    w_nChunks;
    logic [CNT_W-1:0]  w_lastIdx;
    logic              w_isLast;
    logic [ACC_W-1:0]  w_rem;
    logic [XLEN-1:0]   w_xnor;
    logic [XLEN-1:0]   w_mask;
    logic [c_PC_W-1:0] w_pc;
    logic [ACC_W-1:0]  w_msClamped;
    logic [ACC_W-1:0]  w_atLow;
    logic [ACC_W-1:0]  w_atSat;
    logic              w_cfgWrite;
    logic [ACC_W-1:0]  w_sum;
    logic              w_thrHit;

    // Word bookkeeping: index of the final chunk and valid bits in it
    assign w_msRound = {1'b0, r_ms} + (ACC_W+1)'(XLEN - 1);
    assign w_nChunks = w_msRound / (ACC_W+1)'(XLEN);
    assign w_lastIdx = CNT_W'(w_nChunks - 1'b1);
    assign w_isLast  = (r_chunkCnt == w_lastIdx);
    assign w_rem     = r_ms % ACC_W'(XLEN);

    assign w_xnor = ~(op_a ^ op_b);

    // Bits at or above ms%XLEN of the final word lie outside the matrix
    generate
        for (genvar j = 0; j < XLEN; j++) begin : g_mask
            assign w_mask[j] = !(w_isLast && (w_rem != '0) && (ACC_W'(j) >= w_rem));
        end
    endgenerate

    bnn_popcount #(
        .W       (XLEN)
    ) u_popcount (
        .i_data  (w_xnor),
        .i_mask  (w_mask),
        .o_count (w_pc)
    );

    // Clamp a matrix_size write into 1..MAX_MS; saturate the threshold at MAX_MS
    always_comb begin
        if (cfg_data == '0) begin
            w_msClamped = ACC_W'(1);
        end else if (cfg_data > XLEN'(MAX_MS)) begin
            w_msClamped = ACC_W'(MAX_MS);
        end else begin
            w_msClamped = cfg_data[ACC_W-1:0];
        end
    end

    assign w_atLow    = cfg_data[ACC_W-1:0];
    assign w_atSat    = (w_atLow > ACC_W'(MAX_MS)) ? ACC_W'(MAX_MS) : w_atLow;
    assign w_cfgWrite = ms_we || at_we;

    assign w_sum    = r_acc + ACC_W'(r_pc1);
    assign w_thrHit = (w_sum >= r_at);

    // Pipeline update; flush beats config writes, which beat stall and operands
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms          <= ACC_W'(XLEN);
            r_at          <= '0;
            r_chunkCnt    <= '0;
            r_v1          <= 1'b0;
            r_pc1         <= '0;
            r_last1       <= 1'b0;
            r_thr1        <= 1'b0;
            r_acc         <= '0;
            r_resultValid <= 1'b0;
            r_result      <= '0;
        end else begin
            if (ms_we) begin
                r_ms <= w_msClamped;
            end
            if (at_we) begin
                r_at <= w_atSat;
            end

            if (flush || w_cfgWrite) begin
                // Abort the open dot product; a stalled output still holds on config-only writes
                r_chunkCnt <= '0;
                r_acc      <= '0;
                r_v1       <= 1'b0;
                if (flush || !stall) begin
                    r_resultValid <= 1'b0;
                end
            end else if (!stall) begin
                r_v1 <= valid_in;
                if (valid_in) begin
                    r_pc1      <= w_pc;
                    r_last1    <= w_isLast;
                    r_thr1     <= en_threshold;
                    r_chunkCnt <= w_isLast ? '0 : r_chunkCnt + CNT_W'(1);
                end

                r_resultValid <= r_v1 && r_last1;
                if (r_v1) begin
                    if (r_last1) begin
                        r_acc    <= '0;
                        r_result <= r_thr1 ? XLEN'(w_thrHit) : XLEN'(w_sum);
                    end else begin
                        r_acc <= w_sum;
                    end
                end
            end
        end
    end

    assign result_valid = r_resultValid;
    assign result       = r_result;
    assign busy         = (r_chunkCnt != '0) || r_v1;
    assign ms_out       = r_ms;

endmodule
`default_nettype wire

// File: tb/tb_bnn_dot_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_dot_unit
// Description : Self-checking bench for bnn_dot_unit: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_dot_unit;

    localparam int XLEN   = 32;
    localparam int MAX_MS = 1024;
    localparam int ACC_W  = $clog2(MAX_MS + 1);
    localparam int CNT_W  = $clog2((MAX_MS + XLEN - 1) / XLEN + 1);
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             ms_we = 1'b0;
    logic             at_we = 1'b0;
    logic [XLEN-1:0]  cfg_data = '0;
    logic             valid_in = 1'b0;
    logic             en_threshold = 1'b0;
    logic [XLEN-1:0]  op_a = '0;
    logic [XLEN-1:0]  op_b = '0;
    logic             result_valid;
    logic [XLEN-1:0]  result;
    logic             busy;
    logic [ACC_W-1:0] ms_out;

    int nChecks = 0;
    int nErrors = 0;

    // Model state: matrix config, position in the current dot product, and
    // a two-deep result delay line (accepted-last-word slot, visible output)
    int m_ms = XLEN;
    int m_at = 0;
    int m_idx = 0;
    int m_partial = 0;
    bit m_s1 = 1'b0;
    bit m_aV = 1'b0;
    int m_aR = 0;
    bit m_outV = 1'b0;
    int m_outR = 0;

    always #5 clk = ~clk;

    bnn_dot_unit #(
        .XLEN         (XLEN),
        .MAX_MS       (MAX_MS),
        .ACC_W        (ACC_W),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .ms_we        (ms_we),
        .at_we        (at_we),
        .cfg_data     (cfg_data),
        .valid_in     (valid_in),
        .en_threshold (en_threshold),
        .op_a         (op_a),
        .op_b         (op_b),
        .result_valid (result_valid),
        .result       (result),
        .busy         (busy),
        .ms_out       (ms_out)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one update per clock edge from the rules of the unit
    always @(posedge clk) begin : p_model
        int nch;
        int contrib;
        int total;
        int v;
        bit cfgw;
        bit accept;
        if (reset) begin
            m_ms = XLEN; m_at = 0; m_idx = 0; m_partial = 0;
            m_s1 = 0; m_aV = 0; m_aR = 0; m_outV = 0; m_outR = 0;
        end else begin
            cfgw   = ms_we || at_we;
            nch    = (m_ms + XLEN - 1) / XLEN;
            accept = valid_in && !stall && !flush && !cfgw;
            if (flush || cfgw) begin
                m_aV = 0; m_partial = 0; m_idx = 0; m_s1 = 0;
            end
            if (flush) begin
                m_outV = 0;
            end else if (!stall) begin
                m_outV = m_aV;
                m_outR = m_aR;
            end
            if (!stall && !flush) begin
                m_aV = 0;
                m_s1 = 0;
                if (accept) begin
                    contrib = 0;
                    for (int j = 0; j < XLEN; j++) begin
                        if ((m_idx * XLEN + j < m_ms) && (op_a[j] == op_b[j])) contrib++;
                    end
                    total = m_partial + contrib;
                    m_s1 = 1;
                    if (m_idx == nch - 1) begin
                        m_aV = 1;
                        m_aR = en_threshold ? ((total >= m_at) ? 1 : 0) : total;
                        m_partial = 0;
                        m_idx = 0;
                    end else begin
                        m_partial = total;
                        m_idx++;
                    end
                end
            end
            if (ms_we) begin
                if (cfg_data == 32'd0) m_ms = 1;
                else if (cfg_data > 32'(MAX_MS)) m_ms = MAX_MS;
                else m_ms = int'(cfg_data);
            end
            if (at_we) begin
                v = int'(cfg_data[ACC_W-1:0]);
                m_at = (v > MAX_MS) ? MAX_MS : v;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        chk("result_valid", longint'(result_valid), longint'(m_outV));
        if (m_outV) chk("result", longint'(result), longint'(m_outR));
        chk("busy", longint'(busy), longint'((m_idx != 0) || m_s1));
        chk("ms_out", longint'(ms_out), longint'(m_ms));
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic thr);
        valid_in = 1'b1; op_a = a; op_b = b; en_threshold = thr;
        @(negedge clk);
        valid_in = 1'b0; en_threshold = 1'b0;
    endtask

    task automatic cfg(input bit msw, input bit atw, input logic [31:0] d);
        ms_we = msw; at_we = atw; cfg_data = d;
        @(negedge clk);
        ms_we = 1'b0; at_we = 1'b0;
    endtask

    initial begin
        int r;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_rv", longint'(result_valid), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ms", longint'(ms_out), 32);

        // Single word, count mode
        send(ONES, ONES, 1'b0);
        @(negedge clk);
        chk("t1_rv", longint'(result_valid), 1);
        chk("t1_result", longint'(result), 32);
        chk("t1_model", longint'(m_outR), 32);
        @(negedge clk);
        chk("t1_pulse", longint'(result_valid), 0);

        // Masked last chunk
        cfg(1, 0, 32'd40);
        send(ONES, ONES, 1'b0);
        chk("t2_busy", longint'(busy), 1);
        send(ONES, ONES, 1'b0);
        chk("t2_no_early", longint'(result_valid), 0);
        @(negedge clk);
        chk("t2_result", longint'(result), 40);
        chk("t2_model", longint'(m_outR), 40);

        // Threshold mode, back to back
        cfg(1, 0, 32'd32);
        cfg(0, 1, 32'd20);
        send(32'hFFFF_0000, ONES, 1'b1);
        send(32'h00FF_FFFF, ONES, 1'b1);
        chk("t3_rv_a", longint'(result_valid), 1);
        chk("t3_res_a", longint'(result), 0);
        @(negedge clk);
        chk("t3_rv_b", longint'(result_valid), 1);
        chk("t3_res_b", longint'(result), 1);

        // Stall then flush
        cfg(1, 0, 32'd64);
        send(ONES, ONES, 1'b0);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0; flush = 1'b1; valid_in = 1'b1; op_a = ONES; op_b = ONES;
        @(negedge clk);
        flush = 1'b0; valid_in = 1'b0;
        chk("t4_busy", longint'(busy), 0);
        repeat (3) begin
            chk("t4_no_result", longint'(result_valid), 0);
            @(negedge clk);
        end
        send(ONES, ONES, 1'b0);
        send(ONES, 32'h0F0F_0F0F, 1'b0);
        @(negedge clk);
        chk("t4_result", longint'(result), 48);
        chk("t4_model", longint'(m_outR), 48);

        // Config write colliding with an operand
        send(ONES, ONES, 1'b0);
        ms_we = 1'b1; cfg_data = 32'd32; valid_in = 1'b1; op_a = ONES; op_b = ONES;
        @(negedge clk);
        ms_we = 1'b0; valid_in = 1'b0;
        chk("t5_busy", longint'(busy), 0);
        send(32'h0000_FFFF, ONES, 1'b0);
        @(negedge clk);
        chk("t5_rv", longint'(result_valid), 1);
        chk("t5_result", longint'(result), 16);

        // Reset mid-accumulation, clamps and boundary thresholds
        cfg(1, 0, 32'd64);
        send(ONES, ONES, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", longint'(busy), 0);
        chk("t6_ms", longint'(ms_out), 32);
        chk("t6_rv", longint'(result_valid), 0);
        chk("t6_result", longint'(result), 0);
        cfg(1, 0, 32'd0);
        chk("t6_ms_min", longint'(ms_out), 1);
        send(32'h0, ONES, 1'b1);
        @(negedge clk);
        chk("t6_at0", longint'(result), 1);
        cfg(1, 0, 32'd5000);
        chk("t6_ms_max", longint'(ms_out), MAX_MS);
        cfg(0, 1, 32'h000F_FFFF);
        repeat (32) send(ONES, ONES, 1'b1);
        @(negedge clk);
        chk("t6_thr_full", longint'(result), 1);
        repeat (31) send(ONES, ONES, 1'b1);
        send(32'hFFFF_FFFE, ONES, 1'b1);
        @(negedge clk);
        chk("t6_thr_miss", longint'(result), 0);
        repeat (32) send(ONES, ONES, 1'b0);
        @(negedge clk);
        chk("t6_max_count", longint'(result), MAX_MS);
        chk("t6_max_model", longint'(m_outR), MAX_MS);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 999) < 3);
            flush = ($urandom_range(0, 99) < 3);
            stall = ($urandom_range(0, 99) < 12);
            ms_we = ($urandom_range(0, 99) < 2);
            at_we = ($urandom_range(0, 99) < 2);
            if (ms_we) begin
                r = $urandom_range(0, 5);
                case (r)
                    0: cfg_data = 32'($urandom_range(1, 31));
                    1: cfg_data = 32'(32 * $urandom_range(1, 4));
                    2: cfg_data = 32'($urandom_range(33, 140));
                    3: cfg_data = 32'd0;
                    4: cfg_data = 32'($urandom_range(1025, 70000));
                    default: cfg_data = $urandom;
                endcase
            end else if (at_we) begin
                cfg_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100));
            end else begin
                cfg_data = $urandom;
            end
            valid_in = ($urandom_range(0, 99) < 70);
            en_threshold = $urandom_range(0, 1);
            op_a = $urandom;
            op_b = op_a ^ ($urandom & $urandom);
            @(negedge clk);
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0; ms_we = 1'b0; at_we = 1'b0; valid_in = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bnn_dot_unit.md
Name: bnn_dot_unit

Overview:
- Parametrised multi-cycle binary-neural-network dot-product unit for the Skylark-V execute stage.
- Succeeds the single-word XNOR/popcount BNN path; supports matrix_size up to MAX_MS bits.
- Streams one XLEN-bit operand pair per cycle and accumulates masked XNOR-popcounts across ceil(ms/XLEN) words.
- Emits either the raw count or a thresholded activation bit. Sits beside the ALU and is selected by ExPath; responds to the pipeline's stall and flush.

Parameters:
XLEN, 32, operand/result width in bits
MAX_MS, 1024, maximum matrix_size in bits
ACC_W, $clog2(MAX_MS+1), accumulator and count width
CNT_W, $clog2((MAX_MS+XLEN-1)/XLEN+1), chunk counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  freeze all state, including outputs
flush  in  1  abort the in-progress dot product
ms_we  in  1  write matrix_size from cfg_data
at_we  in  1  write activation_threshold from cfg_data
cfg_data  in  XLEN  configuration write value
valid_in  in  1  operand pair present this cycle
en_threshold  in  1  threshold mode for this operand; sampled on the final word
op_a  in  XLEN  activation word
op_b  in  XLEN  weight word
result_valid  out  1  result presented; one-cycle pulse
result  out  XLEN  count, or 0/1 activation
busy  out  1  accumulation open: chunk_cnt != 0 or stage-1 valid
ms_out  out  ACC_W  current matrix_size, for debug/CSR readback

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - result_valid=0, result=0, busy=0.
  - ms=XLEN, at=0, acc=0, chunk_cnt=0.
  - Both pipeline stages invalid.
- Config writes:
  - ms_we: ms <= clamp(cfg_data, 1, MAX_MS).
  - at_we: at <= cfg_data[ACC_W-1:0], saturating at MAX_MS.
  - Any config write clears acc, chunk_cnt and the stage-1 valid. A config write and valid_in in the same cycle: the write wins and the operand is dropped.
  - Writes are honoured during stall.
- Chunk bookkeeping: nchunks = ceil(ms/XLEN). A word is "last" when chunk_cnt == nchunks-1.
- Stage 1, when valid_in & !stall:
  - x = ~(op_a ^ op_b).
  - On the last word, if ms%XLEN != 0, mask bits [XLEN-1 : ms%XLEN] of x to 0.
  - Register pc1 = popcount(x), last1 and thr1 = en_threshold.
  - chunk_cnt increments, or wraps to 0 on the last word.
- Stage 2, when stage-1 valid & !stall:
  - sum = acc + pc1.
  - If last1: acc <= 0; result_valid <= 1 next cycle. result <= thr1 ? (sum >= at ? 1 : 0) : zero-extended sum.
  - Otherwise: acc <= sum; result_valid <= 0.
- Latency: the final word accepted in cycle N gives result_valid in cycle N+2 (without stall). Throughput is one word per cycle, and back-to-back dot products are allowed.
- stall: every register holds, including result_valid and result. A pulse stretches while stalled.
- flush: clears chunk_cnt, acc, stage-1 valid and result_valid in the same edge. It takes priority over valid_in and stall; reset takes priority over flush.
- ms ≤ XLEN: every word is last, giving one result per word.
- ms = MAX_MS: acc reaches MAX_MS without overflow; ACC_W is sized for this.
- Threshold at=0: threshold mode always yields 1.
- Reset mid-accumulation: returns to the reset values above; the partial sum is discarded.

Decomposition:
- Package skylark_bnn_pkg holds: XLEN and MAX_MS defaults, an ACC_W helper function, a cfg_sel_t enum {CFG_MS, CFG_AT}, and the ExPath encoding constant for the BNN path.
- Sub-module bnn_popcount #(W): combinational, masked-input popcount implemented as an adder tree.
- The top contains the counters, both pipeline stages and the threshold compare.

Test Plan:
1. Single word, count mode: ms=32, a=b=0xFFFFFFFF, en_threshold=0 -> result=32 two cycles after accept, result_valid high for exactly 1 cycle.
2. Masked last chunk: ms=40, two words with a=b=0xFFFFFFFF -> word 1 gives no result; result=40 at N+2 after word 2; busy high between the two words.
3. Threshold mode: ms=32, at=20, b=0xFFFFFFFF. a=0xFFFF0000 -> result=0 (count 16). Next cycle a=0x00FFFFFF -> result=1 (count 24).
4. Stall and flush: ms=64, send word 1, assert stall 3 cycles, then flush with word 2 -> no result_valid. A fresh two-word sequence then yields its own correct count, with no residue from the aborted one.
5. Config write mid-stream: ms=64, one word accepted, then ms_we=32 in the same cycle as valid_in -> operand dropped and acc cleared. The next word alone produces result.
6. Reset mid-accumulation, and ms_we with cfg_data=0 and with cfg_data=5000 -> reset values restored; ms_out reads 1 and MAX_MS respectively.
